// File: rtl/led_status_if.sv
// Bundle of LED driver control inputs (val/mode/bright/load) and LED outputs.
// The master drives the pattern and strobe; the slave returns the LED state.
interface led_status_if #(
    parameter int WIDTH    = 6,
    parameter int PWM_BITS = 4
);
    logic [WIDTH-1:0]    val;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] bright;
    logic                load;
    logic [WIDTH-1:0]    led;
    logic                blink_phase;

    modport master (
        output val, mode, bright, load,
        input  led, blink_phase
    );

    modport slave (
        input  val, mode, bright, load,
        output led, blink_phase
    );
endinterface

// File: rtl/led_status_driver.sv
// Registered front-panel LED driver: off, static, blinking or PWM-dimmed pattern.
// Optional LED_BREATHE_EN replaces the DIM brightness with a triangle ramp.
module led_status_driver #(
    parameter int WIDTH    = 6,
    parameter int CLK_HZ   = 100_000_000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    led_status_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_DIM    = 2'b11
    } mode_t;

    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(HALF - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

    generate
        if (HALF < 1) begin : g_half_check
            $error("led_status_driver: CLK_HZ/(2*BLINK_HZ) must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0]    val_reg, val_next;
    mode_t               mode_reg, mode_next;
    logic [PWM_BITS-1:0] bright_reg, bright_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                phase_reg, phase_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
    logic [WIDTH-1:0]    led_reg, led_next;
    logic [PWM_BITS-1:0] duty_level;
    logic                wrap;
    logic                blink_start;
    logic                pwm_on;
    logic                lit;

    always_comb begin
        wrap        = (cnt_reg == CNT_LAST);
        blink_start = bus.load && (mode_t'(bus.mode) == MODE_BLINK) && (mode_reg != MODE_BLINK);

        val_next    = val_reg;
        mode_next   = mode_reg;
        bright_next = bright_reg;
        if (bus.load) begin
            val_next    = bus.val;
            mode_next   = mode_t'(bus.mode);
            bright_next = bus.bright;
        end

        cnt_next   = wrap ? '0 : cnt_reg + 1'b1;
        phase_next = wrap ? ~phase_reg : phase_reg;
        // Entering BLINK restarts the half-period so the pattern shows first.
        if (blink_start) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end

        pwm_cnt_next = pwm_cnt_reg + 1'b1;
        pwm_on       = (duty_level == BRIGHT_MAX) || (pwm_cnt_reg < duty_level);

        lit = 1'b0;
        case (mode_reg)
            MODE_OFF:    lit = 1'b0;
            MODE_STATIC: lit = 1'b1;
            MODE_BLINK:  lit = phase_reg;
            MODE_DIM:    lit = pwm_on;
            default:     lit = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led_bit
            assign led_next[gi] = lit & val_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            val_reg     <= '0;
            mode_reg    <= MODE_OFF;
            bright_reg  <= '0;
            cnt_reg     <= '0;
            phase_reg   <= 1'b0;
            pwm_cnt_reg <= '0;
            led_reg     <= '0;
        end else begin
            val_reg     <= val_next;
            mode_reg    <= mode_next;
            bright_reg  <= bright_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
            pwm_cnt_reg <= pwm_cnt_next;
            led_reg     <= led_next;
        end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] ramp_reg, ramp_next;
    logic                ramp_up_reg, ramp_up_next;

    // Triangle ramp: one step per prescaler wrap, turning at all-ones and zero.
    always_comb begin
        ramp_next    = ramp_reg;
        ramp_up_next = ramp_up_reg;
        if (wrap) begin
            if (ramp_up_reg) begin
                if (ramp_reg == BRIGHT_MAX) begin
                    ramp_up_next = 1'b0;
                    ramp_next    = ramp_reg - 1'b1;
                end else begin
                    ramp_next = ramp_reg + 1'b1;
                end
            end else begin
                if (ramp_reg == '0) begin
                    ramp_up_next = 1'b1;
                    ramp_next    = ramp_reg + 1'b1;
                end else begin
                    ramp_next = ramp_reg - 1'b1;
                end
            end
        end
        if (bus.load && (mode_t'(bus.mode) == MODE_DIM)) begin
            ramp_next    = '0;
            ramp_up_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_reg    <= '0;
            ramp_up_reg <= 1'b1;
        end else begin
            ramp_reg    <= ramp_next;
            ramp_up_reg <= ramp_up_next;
        end
    end

    assign duty_level = ramp_reg;
`else
    assign duty_level = bright_reg;
`endif

    assign bus.led         = led_reg;
    assign bus.blink_phase = phase_reg;
endmodule
